// File: rtl/usb_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : usb_reset_seq
// Description : ULPI PHY reset pulse, DIR-stable wait with timeout/retry, then
//               staggered release of NUM_DOMAINS core resets.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module usb_reset_seq #(
    parameter int PHY_RST_CYCLES    = 16,
    parameter int DIR_STABLE_CYCLES = 8,
    parameter int TIMEOUT_CYCLES    = 4096,
    parameter int MAX_RETRIES       = 3,
    parameter int NUM_DOMAINS       = 2,
    parameter int STAGGER_CYCLES    = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   ulpi_dir_i,
    input  logic                   soft_rst_i,
    input  logic                   core_rst_req_i,
    output logic                   phy_rst_no,
    output logic [NUM_DOMAINS-1:0] core_rst_o,
    output logic                   ready_o,
    output logic                   fail_o,
    output logic [3:0]             retry_cnt_o,
    output logic [2:0]             state_o
);

    localparam int c_MAX_A = (PHY_RST_CYCLES > DIR_STABLE_CYCLES) ? PHY_RST_CYCLES : DIR_STABLE_CYCLES;
    localparam int c_MAX_B = (TIMEOUT_CYCLES > STAGGER_CYCLES) ? TIMEOUT_CYCLES : STAGGER_CYCLES;
    localparam int c_MAX   = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
    localparam int c_CW    = $clog2(c_MAX) + 1;

    localparam logic [2:0] c_PHY_RST   = 3'd0;
    localparam logic [2:0] c_PHY_WAIT  = 3'd1;
    localparam logic [2:0] c_RELEASE   = 3'd2;
    localparam logic [2:0] c_RUN       = 3'd3;
    localparam logic [2:0] c_FAIL      = 3'd4;
    localparam logic [2:0] c_CORE_HOLD = 3'd5;

    localparam logic [c_CW-1:0] c_PHY_LAST  = c_CW'(PHY_RST_CYCLES - 1);
    localparam logic [c_CW-1:0] c_STAB_DONE = c_CW'(DIR_STABLE_CYCLES);
    localparam logic [c_CW-1:0] c_TO_LAST   = c_CW'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CW-1:0] c_STG_LAST  = c_CW'(STAGGER_CYCLES - 1);
    localparam logic [3:0]      c_RETRY_MAX = 4'(MAX_RETRIES);
    localparam logic [3:0]      c_LAST_IDX  = 4'(NUM_DOMAINS - 1);
    localparam logic [NUM_DOMAINS-1:0] c_ALL_ONES = '1;
    // A single domain is fully released on the first RELEASE cycle.
    localparam logic [2:0] c_REL_ENTRY = (NUM_DOMAINS == 1) ? c_RUN : c_RELEASE;

    logic [2:0]             r_state;
    logic [c_CW-1:0]        r_cnt;
    logic [c_CW-1:0]        r_stab;
    logic [3:0]             r_retry;
    logic [3:0]             r_idx;
    logic                   r_phy_rst_n;
    logic [NUM_DOMAINS-1:0] r_core_rst;
    logic                   r_ready;
    logic                   r_fail;

    logic [2:0]             w_state_nxt;
    logic [c_CW-1:0]        w_cnt_nxt;
    logic [c_CW-1:0]        w_stab_nxt;
    logic [c_CW-1:0]        w_stab_inc;
    logic [3:0]             w_retry_nxt;
    logic [3:0]             w_idx_nxt;
    logic                   w_phy_nxt;
    logic [NUM_DOMAINS-1:0] w_core_nxt;
    logic                   w_ready_nxt;
    logic                   w_fail_nxt;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= c_PHY_RST;
            r_cnt       <= '0;
            r_stab      <= '0;
            r_retry     <= '0;
            r_idx       <= '0;
            r_phy_rst_n <= 1'b0;
            r_core_rst  <= c_ALL_ONES;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_stab      <= w_stab_nxt;
            r_retry     <= w_retry_nxt;
            r_idx       <= w_idx_nxt;
            r_phy_rst_n <= w_phy_nxt;
            r_core_rst  <= w_core_nxt;
            r_ready     <= w_ready_nxt;
            r_fail      <= w_fail_nxt;
        end
    end

    assign w_stab_inc = ulpi_dir_i ? '0 : (r_stab + c_CW'(1));

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stab_nxt  = r_stab;
        w_retry_nxt = r_retry;
        w_idx_nxt   = r_idx;
        if (soft_rst_i) begin
            w_state_nxt = c_PHY_RST;
            w_cnt_nxt   = '0;
            w_stab_nxt  = '0;
            w_retry_nxt = '0;
            w_idx_nxt   = '0;
        end else begin
            case (r_state)
                c_PHY_RST: begin
                    if (r_cnt == c_PHY_LAST) begin
                        w_state_nxt = c_PHY_WAIT;
                        w_cnt_nxt   = '0;
                        w_stab_nxt  = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CW'(1);
                    end
                end
                c_PHY_WAIT: begin
                    w_stab_nxt = w_stab_inc;
                    // A stable DIR takes precedence over a coincident timeout.
                    if (w_stab_inc == c_STAB_DONE) begin
                        w_state_nxt = c_REL_ENTRY;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = 4'd1;
                    end else if (r_cnt == c_TO_LAST) begin
                        w_cnt_nxt = '0;
                        if (r_retry < c_RETRY_MAX) begin
                            w_retry_nxt = r_retry + 4'd1;
                            w_state_nxt = c_PHY_RST;
                        end else begin
                            w_state_nxt = c_FAIL;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_CW'(1);
                    end
                end
                c_RELEASE: begin
                    if (core_rst_req_i) begin
                        w_state_nxt = c_CORE_HOLD;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_STG_LAST) begin
                        w_cnt_nxt = '0;
                        w_idx_nxt = r_idx + 4'd1;
                        if (r_idx == c_LAST_IDX) begin
                            w_state_nxt = c_RUN;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_CW'(1);
                    end
                end
                c_RUN: begin
                    if (core_rst_req_i) begin
                        w_state_nxt = c_CORE_HOLD;
                        w_cnt_nxt   = '0;
                    end
                end
                c_FAIL: begin
                    w_state_nxt = c_FAIL;
                end
                c_CORE_HOLD: begin
                    if (r_cnt == c_PHY_LAST) begin
                        w_state_nxt = c_REL_ENTRY;
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = 4'd1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CW'(1);
                    end
                end
                default: begin
                    w_state_nxt = c_PHY_RST;
                    w_cnt_nxt   = '0;
                    w_stab_nxt  = '0;
                    w_retry_nxt = '0;
                    w_idx_nxt   = '0;
                end
            endcase
        end
    end

    // Outputs are registered, so they are derived from the next state.
    always_comb begin
        w_phy_nxt   = (w_state_nxt != c_PHY_RST);
        w_ready_nxt = (w_state_nxt == c_RUN);
        w_fail_nxt  = (w_state_nxt == c_FAIL);
        w_core_nxt  = c_ALL_ONES;
        if (w_state_nxt == c_RUN) begin
            w_core_nxt = '0;
        end else if (w_state_nxt == c_RELEASE) begin
            for (int k = 0; k < NUM_DOMAINS; k++) begin
                w_core_nxt[k] = (4'(k) >= w_idx_nxt);
            end
        end
    end

    assign phy_rst_no  = r_phy_rst_n;
    assign core_rst_o  = r_core_rst;
    assign ready_o     = r_ready;
    assign fail_o      = r_fail;
    assign retry_cnt_o = r_retry;
    assign state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_usb_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_reset_seq
// Description : Directed and randomized bench for usb_reset_seq against an
//               elapsed-time reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_reset_seq;

    localparam int PRC = 16;
    localparam int DSC = 8;
    localparam int TO  = 64;
    localparam int MR  = 2;
    localparam int N   = 2;
    localparam int STG = 4;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         ulpi_dir_i;
    logic         soft_rst_i;
    logic         core_rst_req_i;
    logic         phy_rst_no;
    logic [N-1:0] core_rst_o;
    logic         ready_o;
    logic         fail_o;
    logic [3:0]   retry_cnt_o;
    logic [2:0]   state_o;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase code, cycles since phase entry, DIR-low run, retries.
    int m_phase = 0;
    int m_age   = 0;
    int m_run   = 0;
    int m_retry = 0;

    int p_tab [6] = '{10, 70, 30, 95, 5, 50};

    usb_reset_seq #(
        .PHY_RST_CYCLES    (PRC),
        .DIR_STABLE_CYCLES (DSC),
        .TIMEOUT_CYCLES    (TO),
        .MAX_RETRIES       (MR),
        .NUM_DOMAINS       (N),
        .STAGGER_CYCLES    (STG)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ulpi_dir_i     (ulpi_dir_i),
        .soft_rst_i     (soft_rst_i),
        .core_rst_req_i (core_rst_req_i),
        .phy_rst_no     (phy_rst_no),
        .core_rst_o     (core_rst_o),
        .ready_o        (ready_o),
        .fail_o         (fail_o),
        .retry_cnt_o    (retry_cnt_o),
        .state_o        (state_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_enter(input int p);
        m_phase = p;
        m_age   = 0;
    endtask

    task automatic model_edge(input logic r, input logic d, input logic s, input logic q);
        if (!r || s) begin
            m_enter(0);
            m_run   = 0;
            m_retry = 0;
        end else begin
            case (m_phase)
                0: if (m_age + 1 == PRC) begin m_enter(1); m_run = 0; end else m_age++;
                1: begin
                    m_run = d ? 0 : m_run + 1;
                    if (m_run == DSC) m_enter((N == 1) ? 3 : 2);
                    else if (m_age + 1 == TO) begin
                        if (m_retry < MR) begin m_retry++; m_enter(0); end
                        else m_enter(4);
                    end else m_age++;
                end
                2: if (q) m_enter(5); else if (m_age + 1 == (N - 1) * STG) m_enter(3); else m_age++;
                3: if (q) m_enter(5);
                5: if (m_age + 1 == PRC) m_enter((N == 1) ? 3 : 2); else m_age++;
                default: ;
            endcase
        end
    endtask

    function automatic logic [N-1:0] exp_core();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) begin
            if (m_phase == 2) v[k] = (m_age < k * STG);
            else              v[k] = (m_phase != 3);
        end
        return v;
    endfunction

    task automatic check_model();
        check("phy",   8'(phy_rst_no),  8'(m_phase != 0));
        check("core",  8'(core_rst_o),  8'(exp_core()));
        check("ready", 8'(ready_o),     8'(m_phase == 3));
        check("fail",  8'(fail_o),      8'(m_phase == 4));
        check("retry", 8'(retry_cnt_o), 8'(m_retry));
        check("state", 8'(state_o),     8'(m_phase));
    endtask

    task automatic step();
        @(posedge clk_i);
        model_edge(rst_i, ulpi_dir_i, soft_rst_i, core_rst_req_i);
        #1;
        check_model();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_phy"},   8'(phy_rst_no),  8'd0);
        check({tag, "_core"},  8'(core_rst_o),  8'h3);
        check({tag, "_ready"}, 8'(ready_o),     8'd0);
        check({tag, "_fail"},  8'(fail_o),      8'd0);
        check({tag, "_retry"}, 8'(retry_cnt_o), 8'd0);
        check({tag, "_state"}, 8'(state_o),     8'd0);
    endtask

    initial begin
        int f_phy, f_c0, f_c1, f_rdy, f_fail, pulses, r80, r160;
        logic prev_phy, phy_low_seen;

        rst_i = 1'b0; ulpi_dir_i = 1'b0; soft_rst_i = 1'b0; core_rst_req_i = 1'b0;
        repeat (3) step();
        check_reset_vals("reset");

        // Power-up with DIR low throughout.
        rst_i = 1'b1;
        f_phy = -1; f_c0 = -1; f_c1 = -1; f_rdy = -1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (f_phy < 0 && phy_rst_no)     f_phy = c + 1;
            if (f_c0  < 0 && !core_rst_o[0]) f_c0  = c + 1;
            if (f_c1  < 0 && !core_rst_o[1]) f_c1  = c + 1;
            if (f_rdy < 0 && ready_o)        f_rdy = c + 1;
        end
        check("pu_phy_rise", 8'(f_phy), 8'd16);
        check("pu_core0",    8'(f_c0),  8'd24);
        check("pu_core1",    8'(f_c1),  8'd28);
        check("pu_ready",    8'(f_rdy), 8'd28);

        // One-cycle DIR glitch after five stable cycles delays release by six.
        soft_rst_i = 1'b1; step(); soft_rst_i = 1'b0;
        f_c0 = -1; f_rdy = -1;
        for (int c = 0; c < 40; c++) begin
            ulpi_dir_i = (c == 21);
            step();
            if (f_c0  < 0 && !core_rst_o[0]) f_c0  = c + 1;
            if (f_rdy < 0 && ready_o)        f_rdy = c + 1;
        end
        ulpi_dir_i = 1'b0;
        check("glitch_core0", 8'(f_c0),  8'd30);
        check("glitch_ready", 8'(f_rdy), 8'd34);

        // Timeouts with DIR stuck high: three pulses then FAIL.
        ulpi_dir_i = 1'b1;
        prev_phy = phy_rst_no;
        soft_rst_i = 1'b1; step(); soft_rst_i = 1'b0;
        pulses = (prev_phy && !phy_rst_no) ? 1 : 0;
        prev_phy = phy_rst_no;
        f_fail = -1; r80 = -1; r160 = -1;
        for (int c = 0; c < 260; c++) begin
            step();
            if (prev_phy && !phy_rst_no) pulses++;
            prev_phy = phy_rst_no;
            if (f_fail < 0 && fail_o) f_fail = c + 1;
            if (c == 79)  r80  = int'(retry_cnt_o);
            if (c == 159) r160 = int'(retry_cnt_o);
        end
        check("to_pulses", 8'(pulses), 8'd3);
        check("to_retry1", 8'(r80),    8'd1);
        check("to_retry2", 8'(r160),   8'd2);
        check("to_fail_at", 8'(f_fail), 8'd240);
        check("to_core",   8'(core_rst_o), 8'h3);
        check("to_fail",   8'(fail_o),  8'd1);

        // Recovery from FAIL.
        ulpi_dir_i = 1'b0;
        soft_rst_i = 1'b1; step(); soft_rst_i = 1'b0;
        check("rec_fail",  8'(fail_o),      8'd0);
        check("rec_retry", 8'(retry_cnt_o), 8'd0);
        check("rec_phy",   8'(phy_rst_no),  8'd0);
        repeat (40) step();
        check("rec_ready", 8'(ready_o), 8'd1);

        // Core-only reset from RUN.
        core_rst_req_i = 1'b1; step(); core_rst_req_i = 1'b0;
        check("core_req_core",  8'(core_rst_o), 8'h3);
        check("core_req_ready", 8'(ready_o),    8'd0);
        phy_low_seen = !phy_rst_no;
        f_c0 = -1; f_rdy = -1;
        for (int c = 0; c < 30; c++) begin
            step();
            if (!phy_rst_no) phy_low_seen = 1'b1;
            if (f_c0  < 0 && !core_rst_o[0]) f_c0  = c + 1;
            if (f_rdy < 0 && ready_o)        f_rdy = c + 1;
        end
        check("core_phy_low", 8'(phy_low_seen), 8'd0);
        check("core_core0",   8'(f_c0),  8'd16);
        check("core_ready",   8'(f_rdy), 8'd20);

        // Soft reset outranks a simultaneous core request.
        soft_rst_i = 1'b1; core_rst_req_i = 1'b1; step();
        soft_rst_i = 1'b0; core_rst_req_i = 1'b0;
        check("prio_phy",   8'(phy_rst_no), 8'd0);
        check("prio_state", 8'(state_o),    8'd0);

        // Board reset in the middle of RELEASE.
        repeat (25) step();
        check("mid_state", 8'(state_o), 8'd2);
        rst_i = 1'b0; step(); rst_i = 1'b1;
        check_reset_vals("midrst");

        // Randomized segments with varying DIR-high probability.
        for (int seg = 0; seg < 6; seg++) begin
            for (int i = 0; i < 500; i++) begin
                ulpi_dir_i     = ($urandom_range(0, 99) < p_tab[seg]);
                soft_rst_i     = ($urandom_range(0, 299) == 0);
                core_rst_req_i = ($urandom_range(0, 39) == 0);
                rst_i          = ($urandom_range(0, 599) != 0);
                step();
            end
        end
        rst_i = 1'b1; soft_rst_i = 1'b0; core_rst_req_i = 1'b0; ulpi_dir_i = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
